// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, fetch defaults and the fetch FSM state encoding.
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP = 4;
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DROP, S_OUT} fetch_state_t;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch FSM; registered state and MemReq plus datapath strobes.
module fetch_ctrl
    import cpu_pkg::*;
(
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_enable,
    input  logic         i_stall,
    input  logic         i_branch,
    input  logic         i_ack,
    output fetch_state_t o_state,
    output logic         o_mem_req,
    output logic         o_capture,
    output logic         o_release
);
    fetch_state_t r_state;
    logic         r_mem_req;

    assign o_state   = r_state;
    assign o_mem_req = r_mem_req;
    assign o_capture = (r_state == S_FETCH) && i_ack && !i_branch;
    assign o_release = (r_state == S_OUT) && !i_stall;

    // MemReq is registered from the next state so it is high exactly in FETCH and DROP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_mem_req <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (i_branch && !i_ack) begin
                        r_state   <= S_DROP;
                        r_mem_req <= 1'b1;
                    end else if (i_ack && !i_branch) begin
                        r_state   <= S_OUT;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_state   <= S_FETCH;
                        r_mem_req <= 1'b1;
                    end
                end
                S_DROP: begin
                    if (i_ack) begin
                        r_state   <= i_enable ? S_FETCH : S_IDLE;
                        r_mem_req <= i_enable;
                    end
                end
                S_OUT: begin
                    if (i_branch || !i_stall) begin
                        r_state   <= i_enable ? S_FETCH : S_IDLE;
                        r_mem_req <= i_enable;
                    end
                end
                default: begin
                    r_state   <= i_enable ? S_FETCH : S_IDLE;
                    r_mem_req <= i_enable;
                end
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch stage with branch redirect.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned     PC_STEP  = DEF_PC_STEP
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            Enable,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    input  logic            MemAck,
    input  logic [XLEN-1:0] MemRdata,
    output logic            MemReq,
    output logic [XLEN-1:0] MemAddr,
    output logic [XLEN-1:0] InstrOut,
    output logic [XLEN-1:0] PCOut,
    output logic            Valid
);
    fetch_state_t    w_state;
    logic            w_capture;
    logic            w_release;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pcout;
    logic            r_valid;

    fetch_ctrl u_ctrl (
        .i_clk     (Clk),
        .i_rst     (Rst),
        .i_enable  (Enable),
        .i_stall   (Stall),
        .i_branch  (BranchTaken),
        .i_ack     (MemAck),
        .o_state   (w_state),
        .o_mem_req (MemReq),
        .o_capture (w_capture),
        .o_release (w_release)
    );

    // DROP keeps the abandoned request's address on the bus while PC already holds the target.
    assign MemAddr  = (w_state == S_DROP) ? r_req_addr : r_pc;
    assign InstrOut = r_instr;
    assign PCOut    = r_pcout;
    assign Valid    = r_valid;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc       <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_instr    <= '0;
            r_pcout    <= '0;
            r_valid    <= 1'b0;
        end else begin
            if (w_state == S_FETCH)
                r_req_addr <= r_pc;
            if (BranchTaken)
                r_pc <= BranchTarget;
            else if (w_capture)
                r_pc <= r_pc + XLEN'(PC_STEP);
            if (w_capture) begin
                r_instr <= MemRdata;
                r_pcout <= r_pc;
            end
            r_valid <= w_capture || (r_valid && !BranchTaken && !w_release);
        end
    end
endmodule
